wb_arbiter_2m: RTL and testbench
================================

# wb_arbiter_2m

Two-master, one-slave Wishbone classic arbiter for the pipelined CPU. It lets the instruction-fetch port (m0) and the data-memory port (m1) share a single external Wishbone bus. Each grant covers exactly one transfer: the granted master's signals are muxed onto the slave side, and ack/data are returned only to that master. The block sits between the CPU core's two master interfaces and the SRAM/peripheral bus.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; select width is DATA_WIDTH/8

Clocking is fixed: one clock, `clk`; `reset` is synchronous and active-high.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_wb_cyc_i / m0_wb_stb_i / m0_wb_we_i  in  1 each  IF master control
- m0_wb_adr_i  in  ADDR_WIDTH  IF address
- m0_wb_dat_i  in  DATA_WIDTH  IF write data
- m0_wb_sel_i  in  DATA_WIDTH/8  IF byte select
- m0_wb_ack_o  out  1  ack to IF master
- m0_wb_dat_o  out  DATA_WIDTH  read data to IF master
- m1_wb_*: same set as m0, for the MEM master
- wb_cyc_o / wb_stb_o / wb_we_o  out  1 each  slave-side control
- wb_adr_o  out  ADDR_WIDTH  slave-side address
- wb_dat_o  out  DATA_WIDTH  slave-side write data
- wb_sel_o  out  DATA_WIDTH/8  slave-side byte select
- wb_ack_i  in  1  slave ack
- wb_dat_i  in  DATA_WIDTH  slave read data

## Operation
- Request: `mX_req = mX_wb_cyc_i & mX_wb_stb_i`.
- FSM states:
  - ARB_IDLE
  - ARB_M0: m0 owns the bus
  - ARB_M1: m1 owns the bus
- From ARB_IDLE:
  - only m0_req → ARB_M0
  - only m1_req → ARB_M1
  - both requesting → arbitration rule (see Configuration)
  - neither → stay in ARB_IDLE
- From ARB_Mx:
  - wb_ack_i=1 → ARB_IDLE (one transfer per grant)
  - else mx_wb_cyc_i=0 (master abort) → ARB_IDLE
  - else stay
- `last_grant` register: updated to x on every entry into ARB_Mx.
- Slave-side outputs:
  - in ARB_Mx: a combinational copy of master x's cyc/stb/we/adr/dat/sel
  - in ARB_IDLE: all zero
- Return path:
  - `mx_wb_ack_o = wb_ack_i` only in ARB_Mx; otherwise 0
  - `mx_wb_dat_o = wb_dat_i` only in ARB_Mx; otherwise 0
- wb_ack_i arriving in ARB_IDLE is dropped and forwarded to neither master.
- The non-granted master sees ack=0 and simply keeps its request asserted. No queueing.

## Timing
- Reset values:
  - state = ARB_IDLE
  - last_grant = m0
  - all wb_*_o = 0
  - all mX_wb_ack_o = 0, all mX_wb_dat_o = 0
- Arbitration latency: request sampled in ARB_IDLE at edge N; the slave sees cyc/stb from cycle N+1.
- Ack latency added by the arbiter: 0 (combinational pass-through).
- Back-to-back transfers: at least one ARB_IDLE cycle between grants. Minimum spacing is ack + 1 idle + grant, so each transfer occupies at least 2 cycles plus slave latency.
- Reset asserted mid-transfer: at the next edge the FSM returns to ARB_IDLE and the slave-side cyc drops. The in-flight transfer is abandoned; the master re-requests.
- Simultaneous ack and master cyc drop in ARB_Mx: the ack is forwarded in that cycle, then → ARB_IDLE.
- Master x changes adr while granted: this is a protocol violation. The change passes straight through and is not checked.

## Configuration
- WB_ARB_RR_EN defined: when both masters request in ARB_IDLE, grant goes to the master that is not `last_grant` (round-robin).
- WB_ARB_RR_EN undefined: fixed priority, m1 (MEM) always wins a tie. `last_grant` is still maintained but not used for arbitration.

## Structure
- Package `wb_arb_pkg`:
  - `arb_state_t` enum {ARB_IDLE, ARB_M0, ARB_M1}
  - master index constants `ARB_M0_IDX=0`, `ARB_M1_IDX=1`
- Sub-module `wb_arb_mux`: purely combinational. Selects one master's request bundle onto the slave side, or zero for idle, indexed by the grant.
- FSM and `last_grant` live in the top module.

## Test plan
- Single m0 read:
  - stimulus: m0 cyc/stb, adr=0x8000_0000; slave acks 2 cycles after cyc with dat=0x0000_0013
  - response: wb_adr_o=0x8000_0000 one cycle after request; m0_wb_ack_o=1 with m0_wb_dat_o=0x0000_0013; m1_wb_ack_o stays 0
- Tie, fixed priority (macro off):
  - stimulus: m0 requests adr 0x8000_0004, m1 writes adr 0x8010_0000 dat 0xDEAD_BEEF sel 0xF, same cycle
  - response: m1 is served first (wb_we_o=1); m0 is granted after the idle cycle
- Tie, WB_ARB_RR_EN:
  - stimulus: both masters request continuously for 4 transfers
  - response: grant order m1, m0, m1, m0
- Abort:
  - stimulus: m1 granted, drops cyc before any ack
  - response: ARB_IDLE next cycle; a late ack is not forwarded to either master
- Reset mid-transfer:
  - stimulus: assert reset while m0 is granted
  - response: wb_cyc_o=0 next cycle; all outputs 0
- Stray ack:
  - stimulus: wb_ack_i=1 in ARB_IDLE
  - response: m0_wb_ack_o=0 and m1_wb_ack_o=0

Source files
------------

// File: rtl/wb_arb_pkg.sv
// ----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and constants for the two-master Wishbone arbiter.
//   arb_state_t  : arbiter FSM state (idle, or which master owns the bus)
//   ARB_M0_IDX   : index of the instruction-fetch master (m0)
//   ARB_M1_IDX   : index of the data-memory master (m1)
//   NUM_MASTERS  : number of master ports
//   state_to_idx : maps a grant state to its master index
// ----------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_M0   = 2'd1,
        ARB_M1   = 2'd2
    } arb_state_t;

    localparam int         NUM_MASTERS = 2;
    localparam logic [0:0] ARB_M0_IDX  = 1'b0;
    localparam logic [0:0] ARB_M1_IDX  = 1'b1;

    // Only meaningful for the two grant states; idle maps to m0, which is
    // harmless because callers only use it when a grant is being made.
    function automatic logic [0:0] state_to_idx(input arb_state_t st);
        return (st == ARB_M1) ? ARB_M1_IDX : ARB_M0_IDX;
    endfunction

endpackage

// File: rtl/wb_arb_mux.sv
// ----------------------------------------------------------------------------
// wb_arb_mux
// Purely combinational request mux. Copies the bundle of the master that owns
// the bus (selected by the arbiter state) onto the slave side; drives all
// zeros while the arbiter is idle.
// Ports:
//   state                      : current arbiter state (selects the owner)
//   m_cyc/m_stb/m_we           : per-master control bits, indexed by master
//   m_adr/m_wdat/m_sel         : per-master address, write data, byte select
//   s_cyc/s_stb/s_we           : slave-side control
//   s_adr/s_wdat/s_sel         : slave-side address, write data, byte select
// ----------------------------------------------------------------------------
module wb_arb_mux
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  arb_state_t                                  state,
    input  logic [NUM_MASTERS-1:0]                      m_cyc,
    input  logic [NUM_MASTERS-1:0]                      m_stb,
    input  logic [NUM_MASTERS-1:0]                      m_we,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]      m_adr,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]      m_wdat,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]    m_sel,
    output logic                                        s_cyc,
    output logic                                        s_stb,
    output logic                                        s_we,
    output logic [ADDR_WIDTH-1:0]                       s_adr,
    output logic [DATA_WIDTH-1:0]                       s_wdat,
    output logic [DATA_WIDTH/8-1:0]                     s_sel
);

    logic       sel_valid;
    logic [0:0] sel_idx;

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = ARB_M0_IDX;
        case (state)
            ARB_M0: begin
                sel_valid = 1'b1;
                sel_idx   = ARB_M0_IDX;
            end
            ARB_M1: begin
                sel_valid = 1'b1;
                sel_idx   = ARB_M1_IDX;
            end
            default: begin
                sel_valid = 1'b0;
                sel_idx   = ARB_M0_IDX;
            end
        endcase
    end

    // Whatever the owner drives passes straight through, including address
    // changes mid-transfer; nothing is registered or checked here.
    assign s_cyc  = sel_valid & m_cyc[sel_idx];
    assign s_stb  = sel_valid & m_stb[sel_idx];
    assign s_we   = sel_valid & m_we[sel_idx];
    assign s_adr  = sel_valid ? m_adr[sel_idx]  : '0;
    assign s_wdat = sel_valid ? m_wdat[sel_idx] : '0;
    assign s_sel  = sel_valid ? m_sel[sel_idx]  : '0;

endmodule

// File: rtl/wb_arbiter_2m.sv
// ----------------------------------------------------------------------------
// wb_arbiter_2m
// Two-master, one-slave Wishbone classic arbiter. m0 is the instruction-fetch
// port, m1 the data-memory port. Each grant covers exactly one transfer: the
// grant ends on the slave ack or when the owner drops cyc, and at least one
// idle cycle separates consecutive grants.
//
// Configuration macro:
//   WB_ARB_RR_EN defined   : a tie in idle goes to the master that did not
//                            win last time (round-robin).
//   WB_ARB_RR_EN undefined : a tie always goes to m1 (fixed priority);
//                            last_grant is still tracked.
//
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   mX_wb_cyc_i/stb_i/we_i         : master X control
//   mX_wb_adr_i/dat_i/sel_i        : master X address, write data, byte sel
//   mX_wb_ack_o/dat_o              : ack and read data returned to master X
//   wb_cyc_o/stb_o/we_o            : slave-side control
//   wb_adr_o/dat_o/sel_o           : slave-side address, write data, byte sel
//   wb_ack_i/dat_i                 : slave ack and read data
// ----------------------------------------------------------------------------
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      m0_wb_cyc_i,
    input  logic                      m0_wb_stb_i,
    input  logic                      m0_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]     m0_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]     m0_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_wb_sel_i,
    output logic                      m0_wb_ack_o,
    output logic [DATA_WIDTH-1:0]     m0_wb_dat_o,

    input  logic                      m1_wb_cyc_i,
    input  logic                      m1_wb_stb_i,
    input  logic                      m1_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]     m1_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]     m1_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_wb_sel_i,
    output logic                      m1_wb_ack_o,
    output logic [DATA_WIDTH-1:0]     m1_wb_dat_o,

    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [ADDR_WIDTH-1:0]     wb_adr_o,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
    input  logic                      wb_ack_i,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i
);

    // ------------------------------------------------------------------
    // Gather both masters into index-addressed arrays
    // ------------------------------------------------------------------
    logic [NUM_MASTERS-1:0]                   m_cyc;
    logic [NUM_MASTERS-1:0]                   m_stb;
    logic [NUM_MASTERS-1:0]                   m_we;
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   m_adr;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_wdat;
    logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_sel;
    logic [NUM_MASTERS-1:0]                   m_ack;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_rdat;
    logic [NUM_MASTERS-1:0]                   req;

    assign m_cyc  = {m1_wb_cyc_i, m0_wb_cyc_i};
    assign m_stb  = {m1_wb_stb_i, m0_wb_stb_i};
    assign m_we   = {m1_wb_we_i,  m0_wb_we_i};

    assign m_adr[ARB_M0_IDX]  = m0_wb_adr_i;
    assign m_adr[ARB_M1_IDX]  = m1_wb_adr_i;
    assign m_wdat[ARB_M0_IDX] = m0_wb_dat_i;
    assign m_wdat[ARB_M1_IDX] = m1_wb_dat_i;
    assign m_sel[ARB_M0_IDX]  = m0_wb_sel_i;
    assign m_sel[ARB_M1_IDX]  = m1_wb_sel_i;

    assign req = m_cyc & m_stb;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    arb_state_t state_reg;
    arb_state_t state_next;
    logic [0:0] last_grant_reg;
    logic [0:0] last_grant_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ARB_IDLE;
            last_grant_reg <= ARB_M0_IDX;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (req[ARB_M0_IDX] && req[ARB_M1_IDX]) begin
`ifdef WB_ARB_RR_EN
                    state_next = (last_grant_reg == ARB_M0_IDX) ? ARB_M1 : ARB_M0;
`else
                    state_next = ARB_M1;
`endif
                end else if (req[ARB_M0_IDX]) begin
                    state_next = ARB_M0;
                end else if (req[ARB_M1_IDX]) begin
                    state_next = ARB_M1;
                end
                // Grants are only ever made from idle, so this is the one
                // place last_grant needs to follow the winner.
                if (state_next != ARB_IDLE) begin
                    last_grant_next = state_to_idx(state_next);
                end
            end
            // Ack wins over abort: either way the grant ends this cycle.
            ARB_M0: begin
                if (wb_ack_i || !m_cyc[ARB_M0_IDX]) begin
                    state_next = ARB_IDLE;
                end
            end
            ARB_M1: begin
                if (wb_ack_i || !m_cyc[ARB_M1_IDX]) begin
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (one-hot grant)
    // ------------------------------------------------------------------
    logic [NUM_MASTERS-1:0] grant;

    always_comb begin
        grant = '0;
        case (state_reg)
            ARB_M0:  grant[ARB_M0_IDX] = 1'b1;
            ARB_M1:  grant[ARB_M1_IDX] = 1'b1;
            default: grant = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Request path: owner's bundle onto the slave side
    // ------------------------------------------------------------------
    wb_arb_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .state  (state_reg),
        .m_cyc  (m_cyc),
        .m_stb  (m_stb),
        .m_we   (m_we),
        .m_adr  (m_adr),
        .m_wdat (m_wdat),
        .m_sel  (m_sel),
        .s_cyc  (wb_cyc_o),
        .s_stb  (wb_stb_o),
        .s_we   (wb_we_o),
        .s_adr  (wb_adr_o),
        .s_wdat (wb_dat_o),
        .s_sel  (wb_sel_o)
    );

    // ------------------------------------------------------------------
    // Return path: ack/data only to the owner, zero-latency. An ack seen
    // while idle reaches nobody.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_ret
            assign m_ack[gi]  = grant[gi] & wb_ack_i;
            assign m_rdat[gi] = grant[gi] ? wb_dat_i : '0;
        end
    endgenerate

    assign m0_wb_ack_o = m_ack[ARB_M0_IDX];
    assign m0_wb_dat_o = m_rdat[ARB_M0_IDX];
    assign m1_wb_ack_o = m_ack[ARB_M1_IDX];
    assign m1_wb_dat_o = m_rdat[ARB_M1_IDX];

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// ----------------------------------------------------------------------------
// tb_wb_arbiter_2m
// Directed testbench for wb_arbiter_2m. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled on the falling edge. Expected tie
// order depends on WB_ARB_RR_EN.
// ----------------------------------------------------------------------------
module tb_wb_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk;
    logic          reset;
    logic          m0_cyc, m0_stb, m0_we;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_wdat;
    logic [SW-1:0] m0_sel;
    logic          m0_ack;
    logic [DW-1:0] m0_rdat;
    logic          m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_wdat;
    logic [SW-1:0] m1_sel;
    logic          m1_ack;
    logic [DW-1:0] m1_rdat;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_ack_i;
    logic [DW-1:0] wb_dat_i;

    int n_checks = 0;
    int n_fail   = 0;

    wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_wb_cyc_i (m0_cyc),
        .m0_wb_stb_i (m0_stb),
        .m0_wb_we_i  (m0_we),
        .m0_wb_adr_i (m0_adr),
        .m0_wb_dat_i (m0_wdat),
        .m0_wb_sel_i (m0_sel),
        .m0_wb_ack_o (m0_ack),
        .m0_wb_dat_o (m0_rdat),
        .m1_wb_cyc_i (m1_cyc),
        .m1_wb_stb_i (m1_stb),
        .m1_wb_we_i  (m1_we),
        .m1_wb_adr_i (m1_adr),
        .m1_wb_dat_i (m1_wdat),
        .m1_wb_sel_i (m1_sel),
        .m1_wb_ack_o (m1_ack),
        .m1_wb_dat_o (m1_rdat),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_ack_i    (wb_ack_i),
        .wb_dat_i    (wb_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drop_all();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0; m1_sel = '0;
        wb_ack_i = 0; wb_dat_i = '0;
    endtask

    // Requests and stray acks asserted during reset must not leak anywhere.
    task automatic test_reset();
        drop_all();
        reset = 1;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1234_5678;
        wb_ack_i = 1; wb_dat_i = 32'hAAAA_5555;
        step(); step();
        settle();
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_slave_bus: got cyc=%b adr=%h dat=%h sel=%h want all 0",
                     wb_cyc_o, wb_adr_o, wb_dat_o, wb_sel_o);
        end
        n_checks++;
        if ({m0_ack, m1_ack} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_acks: got m1/m0=%b%b want 00", m1_ack, m0_ack);
        end
        n_checks++;
        if ({m0_rdat, m1_rdat} !== '0) begin
            n_fail++;
            $display("FAIL reset_rdat: got m0=%h m1=%h want 0", m0_rdat, m1_rdat);
        end
        step();
        reset = 0;
        drop_all();
        step();
        $display("txn reset: outputs idle under reset");
    endtask

    task automatic test_single_m0();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h8000_0000; m0_sel = 4'hF;
        settle();
        n_checks++;
        if (wb_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: got wb_cyc_o=%b want 0 before grant edge", wb_cyc_o);
        end
        step();
        settle();
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o} !== {3'b110, 32'h8000_0000, 4'hF}) begin
            n_fail++;
            $display("FAIL single_grant: got cyc/stb/we=%b%b%b adr=%h sel=%h want 110 80000000 f",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o);
        end
        step();
        settle();
        n_checks++;
        if ({wb_cyc_o, m0_ack} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_wait: got cyc=%b m0_ack=%b want 1 0", wb_cyc_o, m0_ack);
        end
        step();
        wb_ack_i = 1; wb_dat_i = 32'h0000_0013;
        settle();
        n_checks++;
        if ({m0_ack, m0_rdat} !== {1'b1, 32'h0000_0013}) begin
            n_fail++;
            $display("FAIL single_ack: got m0_ack=%b m0_dat=%h want 1 00000013", m0_ack, m0_rdat);
        end
        n_checks++;
        if ({m1_ack, m1_rdat} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL single_m1_quiet: got m1_ack=%b m1_dat=%h want 0 0", m1_ack, m1_rdat);
        end
        step();
        drop_all();
        settle();
        n_checks++;
        if ({wb_cyc_o, m0_ack} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_release: got cyc=%b m0_ack=%b want 0 0", wb_cyc_o, m0_ack);
        end
        step();
        $display("txn single_m0: read 80000000 -> %h", 32'h0000_0013);
    endtask

    // last_grant is m0 here, so m1 wins the tie in both arbitration modes.
    task automatic test_tie();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h8000_0004; m0_sel = 4'hF;
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h8010_0000;
        m1_wdat = 32'hDEAD_BEEF; m1_sel = 4'hF;
        step();
        wb_ack_i = 1;
        settle();
        n_checks++;
        if ({wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== {1'b1, 32'h8010_0000, 32'hDEAD_BEEF, 4'hF}) begin
            n_fail++;
            $display("FAIL tie_first_m1: got we=%b adr=%h dat=%h sel=%h want 1 80100000 deadbeef f",
                     wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o);
        end
        n_checks++;
        if ({m1_ack, m0_ack} !== 2'b10) begin
            n_fail++;
            $display("FAIL tie_first_ack: got m1/m0=%b%b want 10", m1_ack, m0_ack);
        end
        step();
        m1_cyc = 0; m1_stb = 0; m1_we = 0; wb_ack_i = 0;
        settle();
        n_checks++;
        if (wb_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_idle_gap: got wb_cyc_o=%b want 0", wb_cyc_o);
        end
        step();
        wb_ack_i = 1; wb_dat_i = 32'h0000_0093;
        settle();
        n_checks++;
        if ({wb_cyc_o, wb_we_o, wb_adr_o} !== {2'b10, 32'h8000_0004}) begin
            n_fail++;
            $display("FAIL tie_second_m0: got cyc=%b we=%b adr=%h want 1 0 80000004",
                     wb_cyc_o, wb_we_o, wb_adr_o);
        end
        n_checks++;
        if ({m1_ack, m0_ack, m0_rdat} !== {2'b01, 32'h0000_0093}) begin
            n_fail++;
            $display("FAIL tie_second_ack: got m1/m0=%b%b m0_dat=%h want 01 00000093",
                     m1_ack, m0_ack, m0_rdat);
        end
        step();
        drop_all();
        step();
        $display("txn tie: m1 write deadbeef then m0 read 00000093");
    endtask

    task automatic test_back_to_back();
        logic exp_order [4];
        logic exp_m;
        logic [DW-1:0] d;
`ifdef WB_ARB_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h8000_0100; m0_sel = 4'hF;
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h8010_0100;
        m1_wdat = 32'h0000_1234; m1_sel = 4'h3;
        step();
        for (int k = 0; k < 4; k++) begin
            exp_m = exp_order[k];
            d = 32'h0000_0100 + 32'(k);
            wb_ack_i = 1; wb_dat_i = d;
            settle();
            n_checks++;
            if (wb_adr_o !== (exp_m ? 32'h8010_0100 : 32'h8000_0100)) begin
                n_fail++;
                $display("FAIL b2b_adr[%0d]: got %h want %h", k, wb_adr_o,
                         exp_m ? 32'h8010_0100 : 32'h8000_0100);
            end
            n_checks++;
            if ({m1_ack, m0_ack} !== (exp_m ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL b2b_ack[%0d]: got m1/m0=%b%b want %b", k, m1_ack, m0_ack,
                         exp_m ? 2'b10 : 2'b01);
            end
            n_checks++;
            if ({m1_rdat, m0_rdat} !== (exp_m ? {d, 32'h0} : {32'h0, d})) begin
                n_fail++;
                $display("FAIL b2b_rdat[%0d]: got m1=%h m0=%h want m%0d=%h", k, m1_rdat, m0_rdat,
                         exp_m, d);
            end
            $display("txn b2b[%0d]: granted m%0d adr=%h", k, exp_m, wb_adr_o);
            step();
            wb_ack_i = 0; wb_dat_i = '0;
            if (k == 3) drop_all();
            settle();
            n_checks++;
            if (wb_cyc_o !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap[%0d]: got wb_cyc_o=%b want 0", k, wb_cyc_o);
            end
            step();
        end
    endtask

    task automatic test_abort();
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h8010_0200; m1_sel = 4'hF;
        step();
        settle();
        n_checks++;
        if ({wb_cyc_o, wb_adr_o} !== {1'b1, 32'h8010_0200}) begin
            n_fail++;
            $display("FAIL abort_grant: got cyc=%b adr=%h want 1 80100200", wb_cyc_o, wb_adr_o);
        end
        step();
        m1_cyc = 0; m1_stb = 0;
        settle();
        n_checks++;
        if (wb_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_cyc_drop: got wb_cyc_o=%b want 0", wb_cyc_o);
        end
        step();
        wb_ack_i = 1; wb_dat_i = 32'h0000_DEAD;
        settle();
        n_checks++;
        if ({m1_ack, m0_ack, m1_rdat, m0_rdat} !== '0) begin
            n_fail++;
            $display("FAIL abort_late_ack: got m1/m0 ack=%b%b m1_dat=%h m0_dat=%h want 0",
                     m1_ack, m0_ack, m1_rdat, m0_rdat);
        end
        step();
        drop_all();
        step();
        $display("txn abort: m1 dropped cyc, late ack discarded");
    endtask

    task automatic test_ack_with_drop();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h8000_0300; m0_sel = 4'hF;
        step();
        m0_cyc = 0; m0_stb = 0;
        wb_ack_i = 1; wb_dat_i = 32'h0000_0077;
        settle();
        n_checks++;
        if ({m0_ack, m0_rdat} !== {1'b1, 32'h0000_0077}) begin
            n_fail++;
            $display("FAIL ackdrop_forward: got m0_ack=%b m0_dat=%h want 1 00000077", m0_ack, m0_rdat);
        end
        step();
        drop_all();
        settle();
        n_checks++;
        if ({wb_cyc_o, m0_ack, m1_ack} !== 3'b000) begin
            n_fail++;
            $display("FAIL ackdrop_idle: got cyc=%b m0_ack=%b m1_ack=%b want 000",
                     wb_cyc_o, m0_ack, m1_ack);
        end
        step();
        $display("txn ack_with_drop: m0 read 00000077");
    endtask

    task automatic test_reset_mid();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h8000_0400;
        m0_wdat = 32'h0000_5555; m0_sel = 4'h1;
        step();
        settle();
        n_checks++;
        if ({wb_cyc_o, wb_we_o, wb_dat_o} !== {2'b11, 32'h0000_5555}) begin
            n_fail++;
            $display("FAIL rstmid_grant: got cyc=%b we=%b dat=%h want 1 1 00005555",
                     wb_cyc_o, wb_we_o, wb_dat_o);
        end
        step();
        reset = 1;
        step();
        wb_ack_i = 1; wb_dat_i = 32'h0000_CAFE;
        settle();
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_slave_bus: got cyc=%b adr=%h dat=%h sel=%h want all 0",
                     wb_cyc_o, wb_adr_o, wb_dat_o, wb_sel_o);
        end
        n_checks++;
        if ({m0_ack, m1_ack, m0_rdat, m1_rdat} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_return: got acks=%b%b m0_dat=%h m1_dat=%h want 0",
                     m0_ack, m1_ack, m0_rdat, m1_rdat);
        end
        step();
        reset = 0;
        drop_all();
        step();
        $display("txn reset_mid: m0 write abandoned by reset");
    endtask

    task automatic test_stray_ack();
        wb_ack_i = 1; wb_dat_i = 32'h0000_1111;
        settle();
        n_checks++;
        if ({m0_ack, m1_ack} !== 2'b00) begin
            n_fail++;
            $display("FAIL stray_ack: got m0_ack=%b m1_ack=%b want 0 0", m0_ack, m1_ack);
        end
        n_checks++;
        if ({m0_rdat, m1_rdat} !== '0) begin
            n_fail++;
            $display("FAIL stray_rdat: got m0=%h m1=%h want 0", m0_rdat, m1_rdat);
        end
        step();
        drop_all();
        step();
        $display("txn stray_ack: idle ack dropped");
    endtask

    initial begin
        reset = 1;
        drop_all();
        test_reset();
        test_single_m0();
        test_tie();
        test_back_to_back();
        test_abort();
        test_ack_with_drop();
        test_reset_mid();
        test_stray_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
